// File: rtl/path_insert_if.sv
// rtl/path_insert_if.sv - insert/advance handshake and path view bundle for path_insert_engine
interface path_insert_if #(
  parameter int DEPTH   = 26,
  parameter int COLOR_W = 4,
  parameter int X_W     = 10
);
  logic                     ins_valid;
  logic                     ins_ready;
  logic [X_W-1:0]           shot_x;
  logic [COLOR_W-1:0]       color_in;
  logic                     adv_valid;
  logic [COLOR_W-1:0]       spawn_color;
  logic [DEPTH*COLOR_W-1:0] path_out;
  logic                     done;
  logic [5:0]               removed_count;
  logic                     ins_err;
  logic                     lost;

  modport master (
    output ins_valid, shot_x, color_in, adv_valid, spawn_color,
    input  ins_ready, path_out, done, removed_count, ins_err, lost
  );

  modport slave (
    input  ins_valid, shot_x, color_in, adv_valid, spawn_color,
    output ins_ready, path_out, done, removed_count, ins_err, lost
  );
endinterface

// File: rtl/path_insert_engine.sv
// rtl/path_insert_engine.sv - sequential ball-path insert, run scan/removal with optional chaining, spawn advance
module path_insert_engine #(
  parameter int DEPTH      = 26,
  parameter int COLOR_W    = 4,
  parameter int X_W        = 10,
  parameter int SLOT_SHIFT = 5,
  parameter int INS_TOP    = 19,
  parameter int MIN_MATCH  = 3,
  parameter int CHAIN      = 1
) (
  input  logic          clk,
  input  logic          reset,
  path_insert_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_SCAN_LO, S_SCAN_HI, S_CLEAR, S_DONE
  } state_e;

  state_e                             state_q, state_d;
  logic [DEPTH-1:0][COLOR_W-1:0]      path_q, path_d;
  logic [IW-1:0]                      p_q, p_d, c_q, c_d, lo_q, lo_d, hi_q, hi_d;
  logic [COLOR_W-1:0]                 col_q, col_d;
  logic [5:0]                         acc_q, acc_d, rc_q, rc_d;
  logic                               done_q, done_d, err_q, err_d, lost_q, lost_d;

  logic [X_W-1:0]                     idx;
  logic                               idx_ok;
  logic [IW:0]                        len;
  logic [6:0]                         acc_sum;
  logic [DEPTH*COLOR_W-1:0]           cleared_flat;
  logic [COLOR_W-1:0]                 jc;

  assign idx    = bus.shot_x >> SLOT_SHIFT;
  assign idx_ok = (idx >= X_W'(1)) && (idx <= X_W'(INS_TOP + 1));

  always_comb begin
    state_d      = state_q;
    path_d       = path_q;
    p_d          = p_q;
    c_d          = c_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    col_d        = col_q;
    acc_d        = acc_q;
    rc_d         = rc_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    lost_d       = 1'b0;
    len          = {1'b0, hi_q} - {1'b0, lo_q} + (IW+1)'(1);
    acc_sum      = 7'(acc_q) + 7'(len);
    // Everything below the run slides up by len; zeros fill in from the exit end.
    cleared_flat = path_q << (len * COLOR_W);
    jc           = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.ins_valid) begin
          if (!idx_ok || bus.color_in == '0) begin
            err_d = 1'b1;
          end else begin
            p_d     = IW'(INS_TOP + 1) - IW'(idx);
            col_d   = bus.color_in;
            c_d     = '0;
            lost_d  = (path_q[0] != '0);
            state_d = S_SHIFT;
          end
        end else if (bus.adv_valid) begin
          path_d = {bus.spawn_color, path_q[DEPTH-1:1]};
          lost_d = (path_q[0] != '0);
        end
      end
      S_SHIFT: begin
        if (c_q < p_q) begin
          path_d[c_q] = path_q[c_q + IW'(1)];
          c_d         = c_q + IW'(1);
        end else begin
          path_d[p_q] = col_q;
          lo_d        = p_q;
          hi_d        = p_q;
          state_d     = S_SCAN_LO;
        end
      end
      S_SCAN_LO: begin
        if (lo_q != '0 && path_q[lo_q - IW'(1)] == col_q) lo_d = lo_q - IW'(1);
        else                                             state_d = S_SCAN_HI;
      end
      S_SCAN_HI: begin
        if (hi_q < IW'(DEPTH - 1) && path_q[hi_q + IW'(1)] == col_q) hi_d = hi_q + IW'(1);
        else if (len >= (IW+1)'(MIN_MATCH))                         state_d = S_CLEAR;
        else                                                        state_d = S_DONE;
      end
      S_CLEAR: begin
        acc_d = (acc_sum > 7'd63) ? 6'd63 : acc_sum[5:0];
        for (int k = 0; k < DEPTH; k++) begin
          if (k <= int'(hi_q)) path_d[k] = cleared_flat[k*COLOR_W +: COLOR_W];
        end
        jc      = path_d[hi_q];
        state_d = S_DONE;
        if (CHAIN == 1 && jc != '0 && hi_q < IW'(DEPTH - 1) &&
            path_q[hi_q + IW'(1)] == jc) begin
          col_d   = jc;
          lo_d    = hi_q;
          state_d = S_SCAN_LO;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        rc_d    = acc_q;
        acc_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      path_q  <= '0;
      p_q     <= '0;
      c_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      p_q     <= p_d;
      c_q     <= c_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.ins_ready     = (state_q == S_IDLE);
  assign bus.path_out      = path_q;
  assign bus.done          = done_q;
  assign bus.removed_count = rc_q;
  assign bus.ins_err       = err_q;
  assign bus.lost          = lost_q;
endmodule
